// File: rtl/midi_note_sender.sv
// midi_note_sender
//   Transmit side of the note path. A 5-slot note snapshot is diffed against
//   the previously accepted set. The block sends note-off messages for notes
//   that were dropped, then note-on messages for notes that were added, as a
//   byte stream on a valid/ready sink such as a UART TX.
//
// Ports
//   clk_camera_in        system clock
//   rst_in               synchronous reset, active low
//   notes_in             snapshot, slot 4..0, 8 bits each (bit 7 ignored, 0 = empty)
//   snapshot_valid_in    snapshot offered
//   snapshot_ready_out   high in IDLE; snapshot accepted on valid && ready
//   flush_in             in IDLE without a snapshot: release every held note
//   byte_out             MIDI byte to sink
//   byte_valid_out       byte_out valid
//   byte_ready_in        sink accepts byte_out
//   busy_out             high in every state except IDLE
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a snapshot or a flush request
// SCAN   | diff pending set against held set, latch the off/on masks
// STATUS | present the status byte of the current event
// NOTE   | present the note byte of the current event
// VEL    | present the velocity byte, then retire the event
module midi_note_sender #(
   parameter logic [3:0] CHANNEL  = 4'd0,
   parameter logic [6:0] VELOCITY = 7'd100
) (
   input  logic            clk_camera_in,
   input  logic            rst_in,
   input  logic [4:0][7:0] notes_in,
   input  logic            snapshot_valid_in,
   output logic            snapshot_ready_out,
   input  logic            flush_in,
   output logic [7:0]      byte_out,
   output logic            byte_valid_out,
   input  logic            byte_ready_in,
   output logic            busy_out
);

   typedef enum logic [2:0] {IDLE, SCAN, STATUS, NOTE, VEL} state_t;

   state_t          state, state_nxt;
   logic [4:0][6:0] held;
   logic [4:0][6:0] pend;
   logic [4:0]      off_mask, on_mask;
   logic [4:0]      off_scan, on_scan;
   logic            sel_off;
   logic [2:0]      idx;
   logic [4:0]      evt_bit;
   logic [6:0]      evt_note;
   logic            events_left;

   // Bit 7 of each slot carries no information for the note path.
   logic [4:0] unused_msb;
   assign unused_msb = {notes_in[4][7], notes_in[3][7], notes_in[2][7],
                        notes_in[1][7], notes_in[0][7]};

   // A slot only raises an event if no higher slot holds the same note, so
   // duplicate notes inside one set produce a single message.
   always_comb begin
      off_scan = '0;
      on_scan  = '0;
      for (int i = 0; i < 5; i++) begin
         off_scan[i] = (held[i] != 7'd0);
         on_scan[i]  = (pend[i] != 7'd0);
         for (int j = 0; j < 5; j++) begin
            if (pend[j] == held[i]) off_scan[i] = 1'b0;
            if (held[j] == pend[i]) on_scan[i]  = 1'b0;
            if (j > i && held[j] == held[i]) off_scan[i] = 1'b0;
            if (j > i && pend[j] == pend[i]) on_scan[i]  = 1'b0;
         end
      end
   end

   // Current event: every note-off is sent before any note-on. Within each
   // group the highest slot is sent first. The masks change only when VEL
   // retires an event, so the selection is stable for all three bytes.
   always_comb begin
      logic [4:0] active;
      sel_off = |off_mask;
      active  = sel_off ? off_mask : on_mask;
      idx     = 3'd0;
      for (int i = 0; i < 5; i++) begin
         if (active[i]) idx = 3'(i);
      end
      evt_bit      = '0;
      evt_bit[idx] = 1'b1;
      evt_note     = sel_off ? held[idx] : pend[idx];
      if (sel_off) events_left = |(off_mask & ~evt_bit) || |on_mask;
      else         events_left = |(on_mask & ~evt_bit);
   end

   always_comb begin
      state_nxt          = state;
      byte_out           = 8'h00;
      byte_valid_out     = 1'b0;
      snapshot_ready_out = 1'b0;
      busy_out           = 1'b1;
      case (state)
         IDLE: begin
            busy_out           = 1'b0;
            snapshot_ready_out = 1'b1;
            if (snapshot_valid_in || flush_in) state_nxt = SCAN;
         end
         SCAN: begin
            if (off_scan == 5'd0 && on_scan == 5'd0) state_nxt = IDLE;
            else                                     state_nxt = STATUS;
         end
         STATUS: begin
            byte_valid_out = 1'b1;
            byte_out       = {(sel_off ? 4'h8 : 4'h9), CHANNEL};
            if (byte_ready_in) state_nxt = NOTE;
         end
         NOTE: begin
            byte_valid_out = 1'b1;
            byte_out       = {1'b0, evt_note};
            if (byte_ready_in) state_nxt = VEL;
         end
         VEL: begin
            byte_valid_out = 1'b1;
            byte_out       = sel_off ? 8'h00 : {1'b0, VELOCITY};
            if (byte_ready_in) state_nxt = events_left ? STATUS : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_camera_in) begin
      if (!rst_in) begin
         state    <= IDLE;
         held     <= '0;
         pend     <= '0;
         off_mask <= '0;
         on_mask  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (snapshot_valid_in) begin
                  for (int i = 0; i < 5; i++) pend[i] <= notes_in[i][6:0];
               end else if (flush_in) begin
                  pend <= '0;
               end
            end
            SCAN: begin
               off_mask <= off_scan;
               on_mask  <= on_scan;
               if (off_scan == 5'd0 && on_scan == 5'd0) held <= pend;
            end
            VEL: begin
               if (byte_ready_in) begin
                  if (sel_off) off_mask <= off_mask & ~evt_bit;
                  else         on_mask  <= on_mask & ~evt_bit;
                  if (!events_left) held <= pend;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_midi_note_sender.sv
module tb_midi_note_sender;

   logic            clk_camera_in = 1'b0;
   logic            rst_in = 1'b0;
   logic [4:0][7:0] notes_in = '0;
   logic            snapshot_valid_in = 1'b0;
   logic            snapshot_ready_out;
   logic            flush_in = 1'b0;
   logic [7:0]      byte_out;
   logic            byte_valid_out;
   logic            byte_ready_in;
   logic            busy_out;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   bit         rand_ready = 1'b0;
   logic       ready_fixed = 1'b1;
   logic       rnd_bit = 1'b1;
   bit         stall_prev = 1'b0;
   logic [7:0] stall_byte = 8'h00;

   assign byte_ready_in = rand_ready ? rnd_bit : ready_fixed;

   midi_note_sender dut (
      .clk_camera_in      (clk_camera_in),
      .rst_in             (rst_in),
      .notes_in           (notes_in),
      .snapshot_valid_in  (snapshot_valid_in),
      .snapshot_ready_out (snapshot_ready_out),
      .flush_in           (flush_in),
      .byte_out           (byte_out),
      .byte_valid_out     (byte_valid_out),
      .byte_ready_in      (byte_ready_in),
      .busy_out           (busy_out)
   );

   always #5 clk_camera_in = ~clk_camera_in;

   always @(posedge clk_camera_in) begin
      #1;
      rnd_bit = 1'($urandom_range(0, 1));
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Capture handshaken bytes and verify byte_out holds during stalls.
   always @(negedge clk_camera_in) begin
      if (byte_valid_out && byte_ready_in) got_q.push_back(byte_out);
      if (stall_prev && byte_valid_out && rst_in) check("stall_hold", byte_out, stall_byte);
      stall_prev = byte_valid_out && !byte_ready_in && rst_in;
      stall_byte = byte_out;
   end

   task automatic tick();
      @(posedge clk_camera_in);
      #1;
   endtask

   task automatic wait_ready(input string tag);
      for (int i = 0; i < 500 && !snapshot_ready_out; i++) tick();
      check(tag, snapshot_ready_out, 1);
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 500 && busy_out; i++) tick();
      check(tag, busy_out, 0);
   endtask

   task automatic send(input logic [4:0][7:0] n, input logic with_flush);
      wait_ready("send_ready");
      notes_in          = n;
      snapshot_valid_in = 1'b1;
      flush_in          = with_flush;
      tick();
      snapshot_valid_in = 1'b0;
      flush_in          = 1'b0;
      notes_in          = {5{8'hFF}};
   endtask

   task automatic flush();
      wait_ready("flush_ready");
      flush_in = 1'b1;
      tick();
      flush_in = 1'b0;
   endtask

   task automatic exp3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      exp_q.push_back(a);
      exp_q.push_back(b);
      exp_q.push_back(c);
   endtask

   task automatic expect_stream(input string tag);
      check({tag, "_len"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      // reset
      rst_in = 1'b0;
      repeat (3) tick();
      rst_in = 1'b1;
      check("rst_ready", snapshot_ready_out, 1);
      check("rst_valid", byte_valid_out, 0);
      check("rst_busy", busy_out, 0);
      check("rst_byte", byte_out, 8'h00);

      // 1: first note, with latency and message length
      send({8'd60, 8'd0, 8'd0, 8'd0, 8'd0}, 1'b0);
      check("t1_scan_busy", busy_out, 1);
      check("t1_scan_valid", byte_valid_out, 0);
      tick();
      check("t1_first_valid", byte_valid_out, 1);
      check("t1_first_byte", byte_out, 8'h90);
      repeat (3) tick();
      check("t1_done_busy", busy_out, 0);
      check("t1_done_ready", snapshot_ready_out, 1);
      exp3(8'h90, 8'h3C, 8'h64);
      expect_stream("t1");

      // 2: 60 moves to slot 0 (bit 7 set, ignored), 64 added
      send({8'd0, 8'd0, 8'd64, 8'd0, 8'hBC}, 1'b0);
      wait_idle("t2_idle");
      exp3(8'h90, 8'h40, 8'h64);
      expect_stream("t2");

      // 3: both off, slot 2 before slot 0, then on
      send({8'd62, 8'd0, 8'd0, 8'd0, 8'd0}, 1'b0);
      wait_idle("t3_idle");
      exp3(8'h80, 8'h40, 8'h00);
      exp3(8'h80, 8'h3C, 8'h00);
      exp3(8'h90, 8'h3E, 8'h64);
      expect_stream("t3");

      // flush the held set
      flush();
      wait_idle("fl1_idle");
      exp3(8'h80, 8'h3E, 8'h00);
      expect_stream("fl1");

      // no-change snapshot: one busy cycle, no bytes
      send('0, 1'b0);
      check("nc_scan_busy", busy_out, 1);
      tick();
      check("nc_busy", busy_out, 0);
      expect_stream("nc");

      // 4: duplicates
      send({8'd60, 8'd60, 8'd0, 8'd0, 8'd0}, 1'b0);
      wait_idle("t4_idle");
      exp3(8'h90, 8'h3C, 8'h64);
      expect_stream("t4_on");
      flush();
      wait_idle("t4_fl_idle");
      exp3(8'h80, 8'h3C, 8'h00);
      expect_stream("t4_off");

      // valid and flush together: valid wins
      send({8'd70, 8'd0, 8'd0, 8'd0, 8'd0}, 1'b1);
      wait_idle("vf_idle");
      exp3(8'h90, 8'h46, 8'h64);
      expect_stream("vf");

      // 5: random back-pressure
      rand_ready = 1'b1;
      send({8'd1, 8'd2, 8'd3, 8'd4, 8'd5}, 1'b0);
      wait_idle("t5_idle");
      exp3(8'h80, 8'h46, 8'h00);
      for (int k = 1; k <= 5; k++) exp3(8'h90, 8'(k), 8'h64);
      expect_stream("t5_on");
      flush();
      wait_idle("t5_fl_idle");
      for (int k = 1; k <= 5; k++) exp3(8'h80, 8'(k), 8'h00);
      expect_stream("t5_off");
      rand_ready = 1'b0;

      // 6: reset during second byte
      ready_fixed = 1'b0;
      send({8'd60, 8'd0, 8'd0, 8'd0, 8'd0}, 1'b0);
      tick();
      check("t6_status", byte_out, 8'h90);
      ready_fixed = 1'b1;
      tick();
      ready_fixed = 1'b0;
      check("t6_note_valid", byte_valid_out, 1);
      check("t6_note", byte_out, 8'h3C);
      rst_in = 1'b0;
      tick();
      check("t6_rst_valid", byte_valid_out, 0);
      check("t6_rst_ready", snapshot_ready_out, 1);
      check("t6_rst_busy", busy_out, 0);
      rst_in = 1'b1;
      ready_fixed = 1'b1;
      exp_q.push_back(8'h90);
      expect_stream("t6_partial");
      send({8'd60, 8'd0, 8'd0, 8'd0, 8'd0}, 1'b0);
      wait_idle("t6_idle");
      exp3(8'h90, 8'h3C, 8'h64);
      expect_stream("t6_resend");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
